// File: rtl/cs_result_fifo.sv
// Result buffer behind the CS datapath: drops the warm-up outputs, then queues Y in a show-ahead FIFO.
// Optional running checksum of pushed samples is enabled by defining CS_RF_CHECKSUM_EN.
module cs_result_fifo #(
  parameter int DEPTH  = 16,
  parameter int WARMUP = 8,
  parameter int LVL_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             y_en,
  input  logic [9:0]       y_in,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [9:0]       out_data,
  output logic [LVL_W-1:0] level,
  output logic             overflow
`ifdef CS_RF_CHECKSUM_EN
  ,
  output logic [15:0]      chk
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int WCNT_W = $clog2(WARMUP + 2);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);
  localparam logic [WCNT_W-1:0] WARM_DONE = WCNT_W'(WARMUP);

  logic [9:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [WCNT_W-1:0] r_wcnt;
  logic             r_valid;
  logic             r_overflow;

  logic             w_full;
  logic             w_warm;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [LVL_W-1:0] w_level_next;

  assign w_full = (r_level == FULL_LVL);
  assign w_warm = (r_wcnt == WARM_DONE);
  assign w_pop  = r_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push = y_en & w_warm & (~w_full | w_pop);
  assign w_drop = y_en & w_warm & w_full & ~w_pop;

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LVL_W'(1);
      2'b01:   w_level_next = r_level - LVL_W'(1);
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_wcnt     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_wcnt     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (y_en && !w_warm) begin
        r_wcnt <= r_wcnt + WCNT_W'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level <= w_level_next;
      r_valid <= (w_level_next != '0);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage is never reset; stale contents are masked from out_data by r_valid.
  always_ff @(posedge clk) begin
    if (reset && !flush && w_push) begin
      r_mem[r_wr_ptr] <= y_in;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_valid ? r_mem[r_rd_ptr] : 10'd0;
  assign level     = r_level;
  assign overflow  = r_overflow;

`ifdef CS_RF_CHECKSUM_EN
  logic [15:0] r_chk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chk <= '0;
    end else if (flush) begin
      r_chk <= '0;
    end else if (w_push) begin
      r_chk <= r_chk + {6'd0, y_in};
    end
  end

  assign chk = r_chk;
`endif

endmodule

// File: tb/tb_cs_result_fifo.sv
// Directed, table-driven bench for cs_result_fifo: warm-up, streaming, full/drop, flush, async reset.
module tb_cs_result_fifo;

  localparam int DEPTH = 16;
  localparam int LVL_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             y_en = 1'b0;
  logic [9:0]       y_in = '0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [9:0]       out_data;
  logic [LVL_W-1:0] level;
  logic             overflow;
`ifdef CS_RF_CHECKSUM_EN
  logic [15:0]      chk;
`endif

  cs_result_fifo #(.DEPTH(DEPTH), .WARMUP(8), .LVL_W(LVL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .y_en      (y_en),
    .y_in      (y_in),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow)
`ifdef CS_RF_CHECKSUM_EN
    ,
    .chk       (chk)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             en;
    logic [9:0]       din;
    logic             fl;
    logic             rdy;
    logic             ev;
    logic [9:0]       ed;
    logic [LVL_W-1:0] el;
    logic             eo;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic add_v(input logic en, input logic [9:0] din, input logic fl, input logic rdy,
                       input logic ev, input logic [9:0] ed, input logic [LVL_W-1:0] el, input logic eo);
    vec_t v;
    v.en = en; v.din = din; v.fl = fl; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
    vq.push_back(v);
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic en, input logic [9:0] din, input logic fl, input logic rdy);
    @(negedge clk);
    y_en = en; y_in = din; flush = fl; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic run_from(input int first);
    for (int i = first; i < vq.size(); i++) begin
      step(vq[i].en, vq[i].din, vq[i].fl, vq[i].rdy);
      $display("vec %0d: en=%0d in=0x%03h fl=%0d rdy=%0d -> valid=%0d data=0x%03h level=%0d ovf=%0d",
               i, vq[i].en, vq[i].din, vq[i].fl, vq[i].rdy, out_valid, out_data, level, overflow);
      check("valid", i, 16'(out_valid), 16'(vq[i].ev));
      check("data", i, 16'(out_data), 16'(vq[i].ed));
      check("level", i, 16'(level), 16'(vq[i].el));
      check("overflow", i, 16'(overflow), 16'(vq[i].eo));
    end
  endtask

  // Eight discarded samples starting at base, then keep (into an empty FIFO).
  task automatic add_warmup(input logic [9:0] base, input logic [9:0] keep);
    for (int k = 0; k < 8; k++) add_v(1'b1, base + 10'(k), 1'b0, 1'b0, 1'b0, 10'd0, 5'd0, 1'b0);
    add_v(1'b1, keep, 1'b0, 1'b0, 1'b1, keep, 5'd1, 1'b0);
  endtask

  initial begin
    int seg2;
    int idx;
`ifdef CS_RF_CHECKSUM_EN
    logic [15:0] exp_chk;
`endif

    // Warm-up with y_in = 1..9, ready low; the 9th is the first kept result.
    for (int k = 1; k <= 8; k++) add_v(1'b1, 10'(k), 1'b0, 1'b0, 1'b0, 10'd0, 5'd0, 1'b0);
    add_v(1'b1, 10'd9, 1'b0, 1'b0, 1'b1, 10'd9, 5'd1, 1'b0);
    // Streaming: each new sample replaces the popped head.
    for (int v = 10; v <= 40; v++) add_v(1'b1, 10'(v), 1'b0, 1'b1, 1'b1, 10'(v), 5'd1, 1'b0);
    add_v(1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 10'd0, 5'd0, 1'b0);
    add_v(1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 10'd0, 5'd0, 1'b0);
    add_v(1'b1, 10'h0EE, 1'b0, 1'b1, 1'b1, 10'h0EE, 5'd1, 1'b0);
    add_v(1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 10'd0, 5'd0, 1'b0);
    // Fill with 17 samples; the 17th is dropped and sets overflow.
    for (int k = 0; k <= 16; k++)
      add_v(1'b1, 10'h100 + 10'(k), 1'b0, 1'b0, 1'b1, 10'h100, (k < 16) ? 5'(k + 1) : 5'd16, (k == 16));
    for (int j = 0; j < 16; j++)
      add_v(1'b0, 10'd0, 1'b0, 1'b1, (j < 15), (j < 15) ? 10'h101 + 10'(j) : 10'd0, 5'(15 - j), 1'b1);
    // Flush with a sample present: sample discarded, overflow cleared, new warm-up.
    add_v(1'b1, 10'h3AA, 1'b1, 1'b0, 1'b0, 10'd0, 5'd0, 1'b0);
    add_warmup(10'h200, 10'h055);
    for (int k = 1; k <= 15; k++)
      add_v(1'b1, 10'h055 + 10'(k), 1'b0, 1'b0, 1'b1, 10'h055, 5'(k + 1), 1'b0);
    // Full with simultaneous push and pop: level holds at DEPTH, no overflow.
    for (int m = 0; m < 3; m++)
      add_v(1'b1, 10'h300 + 10'(m), 1'b0, 1'b1, 1'b1, 10'h056 + 10'(m), 5'd16, 1'b0);
    // Remaining order: 0x058..0x064 (13 entries) then 0x300..0x302.
    for (int j = 0; j < 16; j++) begin
      idx = j + 1;
      add_v(1'b0, 10'd0, 1'b0, 1'b1, (idx < 16),
            (idx < 13) ? 10'h058 + 10'(idx) : (idx < 16) ? 10'h300 + 10'(idx - 13) : 10'd0,
            5'(15 - j), 1'b0);
    end
    // Flush at level 5 with y_en and out_ready high; flush wins.
    for (int k = 0; k < 5; k++) add_v(1'b1, 10'h011 + 10'(k), 1'b0, 1'b0, 1'b1, 10'h011, 5'(k + 1), 1'b0);
    add_v(1'b1, 10'h3BB, 1'b1, 1'b1, 1'b0, 10'd0, 5'd0, 1'b0);
    add_warmup(10'h020, 10'h0AB);
    for (int k = 1; k <= 4; k++) add_v(1'b1, 10'h0AB + 10'(k), 1'b0, 1'b0, 1'b1, 10'h0AB, 5'(k + 1), 1'b0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 0, 16'(out_valid), 16'd0);
    check("rst_data", 0, 16'(out_data), 16'd0);
    check("rst_level", 0, 16'(level), 16'd0);
    check("rst_overflow", 0, 16'(overflow), 16'd0);
`ifdef CS_RF_CHECKSUM_EN
    check("rst_chk", 0, chk, 16'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    run_from(0);

    // Asynchronous reset between edges at level 5: outputs clear before the next edge.
    #2;
    reset = 1'b0;
    #1;
    $display("async reset: valid=%0d data=0x%03h level=%0d ovf=%0d", out_valid, out_data, level, overflow);
    check("arst_valid", 0, 16'(out_valid), 16'd0);
    check("arst_data", 0, 16'(out_data), 16'd0);
    check("arst_level", 0, 16'(level), 16'd0);
    check("arst_overflow", 0, 16'(overflow), 16'd0);
    y_en = 1'b0; flush = 1'b0; out_ready = 1'b0; y_in = '0;
    @(negedge clk);
    reset = 1'b1;

    seg2 = vq.size();
    add_warmup(10'h040, 10'h0CD);
    add_v(1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 10'd0, 5'd0, 1'b0);
    run_from(seg2);

`ifdef CS_RF_CHECKSUM_EN
    step(1'b1, 10'h3FF, 1'b1, 1'b0);
    check("chk_flush", 0, chk, 16'd0);
    for (int k = 0; k < 8; k++) step(1'b1, 10'h3FF, 1'b0, 1'b1);
    check("chk_warm", 0, chk, 16'd0);
    for (int k = 0; k < 100; k++) step(1'b1, 10'h3FF, 1'b0, 1'b1);
    exp_chk = 16'((100 * 1023) % 65536);
    $display("checksum after 100 x 0x3FF: chk=0x%04h", chk);
    check("chk_sum", 0, chk, exp_chk);
    step(1'b0, 10'd0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) step(1'b1, 10'h001, 1'b0, 1'b0);
    exp_chk = exp_chk + 16'd16;
    step(1'b1, 10'h3FF, 1'b0, 1'b0);
    $display("checksum after drop: chk=0x%04h ovf=%0d", chk, overflow);
    check("chk_drop", 0, chk, exp_chk);
    check("chk_drop_ovf", 0, 16'(overflow), 16'd1);
    step(1'b0, 10'd0, 1'b1, 1'b0);
    check("chk_clear", 0, chk, 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
